// File: rtl/wr_level_monitor.sv
// Write-domain FIFO occupancy monitor: synchronizes the Gray read pointer,
// derives a registered level, and flags near-full, overflow and pointer faults.
module wr_level_monitor #(
   parameter int FIFO_addr_size = 2,
   parameter int SYNC_STAGES    = 2,
   parameter int AFULL_SET      = 3,
   parameter int AFULL_CLR      = 1
) (
   input  logic                      clk_w,
   input  logic                      rst_w,
   input  logic [FIFO_addr_size:0]   r_pointer_gray,
   input  logic [FIFO_addr_size:0]   w_pointer_gray,
   input  logic                      w_en,
   input  logic                      full_in,
   input  logic                      clr_err,
   output logic [FIFO_addr_size:0]   r_pointer_gray_sync,
   output logic [FIFO_addr_size:0]   wr_level,
   output logic                      almost_full,
   output logic                      overflow_err,
   output logic [7:0]                overflow_cnt,
   output logic                      ptr_err
);

   localparam int PW = FIFO_addr_size + 1;
   localparam logic [PW-1:0] DEPTH_L = PW'(1 << FIFO_addr_size);
   localparam logic [PW-1:0] SET_L   = PW'(AFULL_SET);
   localparam logic [PW-1:0] CLR_L   = PW'(AFULL_CLR);

   localparam logic [0:0] ST_NORMAL    = 1'b0;
   localparam logic [0:0] ST_NEAR_FULL = 1'b1;

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b[PW-1] = g[PW-1];
      for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   logic [SYNC_STAGES-1:0][PW-1:0] sync_q, sync_d;
   logic [PW-1:0] wr_level_q, wr_level_d;
   logic [0:0]    state_q, state_d;
   logic          overflow_err_q, overflow_err_d;
   logic [7:0]    overflow_cnt_q, overflow_cnt_d;
   logic          ptr_err_q, ptr_err_d;
   logic          ovf_set, ptr_set;

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = r_pointer_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
   end

   // Subtraction modulo 2^PW handles pointer wrap without extra logic.
   always_comb begin
      wr_level_d = gray2bin(w_pointer_gray) - gray2bin(sync_q[SYNC_STAGES-1]);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_NORMAL:    if (wr_level_q >= SET_L) state_d = ST_NEAR_FULL;
         ST_NEAR_FULL: if (wr_level_q <= CLR_L) state_d = ST_NORMAL;
         default:      state_d = ST_NORMAL;
      endcase
   end

   // A new error event in the same cycle as clr_err wins over the clear.
   always_comb begin
      ovf_set        = w_en & full_in;
      ptr_set        = wr_level_q > DEPTH_L;
      overflow_err_d = overflow_err_q;
      overflow_cnt_d = overflow_cnt_q;
      ptr_err_d      = ptr_err_q;
      if (ovf_set) begin
         overflow_err_d = 1'b1;
         if (clr_err)                    overflow_cnt_d = 8'd1;
         else if (overflow_cnt_q != 8'hFF) overflow_cnt_d = overflow_cnt_q + 8'd1;
      end else if (clr_err) begin
         overflow_err_d = 1'b0;
         overflow_cnt_d = 8'd0;
      end
      if (ptr_set)      ptr_err_d = 1'b1;
      else if (clr_err) ptr_err_d = 1'b0;
   end

   always_ff @(posedge clk_w or negedge rst_w) begin
      if (!rst_w) begin
         sync_q         <= '0;
         wr_level_q     <= '0;
         state_q        <= ST_NORMAL;
         overflow_err_q <= 1'b0;
         overflow_cnt_q <= 8'd0;
         ptr_err_q      <= 1'b0;
      end else begin
         sync_q         <= sync_d;
         wr_level_q     <= wr_level_d;
         state_q        <= state_d;
         overflow_err_q <= overflow_err_d;
         overflow_cnt_q <= overflow_cnt_d;
         ptr_err_q      <= ptr_err_d;
      end
   end

   assign r_pointer_gray_sync = sync_q[SYNC_STAGES-1];
   assign wr_level            = wr_level_q;
   assign almost_full         = (state_q == ST_NEAR_FULL);
   assign overflow_err        = overflow_err_q;
   assign overflow_cnt        = overflow_cnt_q;
   assign ptr_err             = ptr_err_q;

endmodule

// File: tb/tb_wr_level_monitor.sv
// Directed self-checking bench for wr_level_monitor at default parameters.
module tb_wr_level_monitor;

   logic       clk_w = 1'b0;
   logic       rst_w;
   logic [2:0] r_pointer_gray, w_pointer_gray;
   logic       w_en, full_in, clr_err;
   logic [2:0] r_pointer_gray_sync, wr_level;
   logic       almost_full, overflow_err, ptr_err;
   logic [7:0] overflow_cnt;

   int checks   = 0;
   int failures = 0;

   wr_level_monitor dut (
      .clk_w              (clk_w),
      .rst_w              (rst_w),
      .r_pointer_gray     (r_pointer_gray),
      .w_pointer_gray     (w_pointer_gray),
      .w_en               (w_en),
      .full_in            (full_in),
      .clr_err            (clr_err),
      .r_pointer_gray_sync(r_pointer_gray_sync),
      .wr_level           (wr_level),
      .almost_full        (almost_full),
      .overflow_err       (overflow_err),
      .overflow_cnt       (overflow_cnt),
      .ptr_err            (ptr_err)
   );

   always #5 clk_w = ~clk_w;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk_w);
      #1;
   endtask

   // Gray codes for binary 0..5
   localparam logic [2:0] G0 = 3'b000, G1 = 3'b001, G2 = 3'b011,
                          G3 = 3'b010, G4 = 3'b110, G5 = 3'b111;

   int lv [5] = '{0, 3, 2, 1, 2};
   int af [5] = '{0, 1, 1, 0, 0};
   logic [2:0] gv [5] = '{G0, G3, G2, G1, G2};

   initial begin
      int prev_af;
      rst_w = 1'b0; r_pointer_gray = G0; w_pointer_gray = G2;
      w_en = 1'b0; full_in = 1'b0; clr_err = 1'b0;
      #12;
      chk("rst_sync", r_pointer_gray_sync, 0);
      chk("rst_level", wr_level, 0);
      chk("rst_af", almost_full, 0);
      chk("rst_oerr", overflow_err, 0);
      chk("rst_ocnt", overflow_cnt, 0);
      chk("rst_perr", ptr_err, 0);

      // Latency: r changes right after edge 0
      rst_w = 1'b1;
      tick();                   // edge 0
      r_pointer_gray = G1;
      tick();                   // edge 1
      chk("lat_sync_e1", r_pointer_gray_sync, 0);
      tick();                   // edge 2
      chk("lat_sync_e2", r_pointer_gray_sync, 1);
      chk("lat_level_e2", wr_level, 2);
      tick();                   // edge 3
      chk("lat_level_e3", wr_level, 1);

      // Level with wrap: w=0, r=6 -> 2
      r_pointer_gray = 3'b101;
      tick(4);
      w_pointer_gray = G0;
      tick(2);
      chk("wrap_level2", wr_level, 2);
      r_pointer_gray = G0;
      tick(4);
      chk("level0", wr_level, 0);
      w_pointer_gray = G4;
      tick();
      chk("level4", wr_level, 4);
      tick();
      chk("level4_af", almost_full, 1);
      chk("level4_perr", ptr_err, 0);

      // Hysteresis
      prev_af = 1;
      for (int i = 0; i < 5; i++) begin
         w_pointer_gray = gv[i];
         tick();
         chk($sformatf("hys_level%0d", i), wr_level, lv[i]);
         chk($sformatf("hys_af_hold%0d", i), almost_full, prev_af);
         tick();
         chk($sformatf("hys_af%0d", i), almost_full, af[i]);
         prev_af = af[i];
      end

      // Overflow saturation and clear
      w_en = 1'b1; full_in = 1'b1;
      tick();
      chk("ovf_cnt1", overflow_cnt, 1);
      chk("ovf_err1", overflow_err, 1);
      tick(299);
      chk("ovf_err_sat", overflow_err, 1);
      chk("ovf_cnt_sat", overflow_cnt, 255);
      w_en = 1'b0; clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("clr_err", overflow_err, 0);
      chk("clr_cnt", overflow_cnt, 0);

      // Set wins over clear
      tick();
      w_en = 1'b1; clr_err = 1'b1;
      tick();
      chk("coll_err", overflow_err, 1);
      chk("coll_cnt", overflow_cnt, 1);
      tick();
      chk("coll_cnt2", overflow_cnt, 1);
      w_en = 1'b0; full_in = 1'b0; clr_err = 1'b0;

      // ptr_err: level 5 exceeds depth 4
      w_pointer_gray = G5;
      tick();
      chk("perr_level5", wr_level, 5);
      chk("perr_pre", ptr_err, 0);
      tick();
      chk("perr_set", ptr_err, 1);
      w_pointer_gray = G0;
      tick(2);
      chk("perr_sticky", ptr_err, 1);
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      chk("perr_clr", ptr_err, 0);
      chk("perr_clr_ocnt", overflow_cnt, 0);

      // Mid-operation async reset
      tick(2);
      w_pointer_gray = G3;
      tick(2);
      w_en = 1'b1; full_in = 1'b1;
      tick(7);
      w_en = 1'b0; full_in = 1'b0;
      chk("pre_rst_level", wr_level, 3);
      chk("pre_rst_af", almost_full, 1);
      chk("pre_rst_ocnt", overflow_cnt, 7);
      r_pointer_gray = G1;
      tick(2);
      chk("pre_rst_sync", r_pointer_gray_sync, 1);
      #2 rst_w = 1'b0;
      #1;
      chk("mid_rst_level", wr_level, 0);
      chk("mid_rst_af", almost_full, 0);
      chk("mid_rst_ocnt", overflow_cnt, 0);
      chk("mid_rst_oerr", overflow_err, 0);
      chk("mid_rst_sync", r_pointer_gray_sync, 0);
      @(negedge clk_w);
      rst_w = 1'b1;
      tick();
      chk("post_rst_level", wr_level, 3);
      tick(2);
      chk("post_rst_level_sync", wr_level, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
